// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared select codes, FSM states and sign helpers for the M-extension sequencer
package muldiv_pkg;

  localparam int W64 = 64;
  localparam int W32 = 32;

  localparam logic [4:0] SEL_MUL   = 5'd2;
  localparam logic [4:0] SEL_DIV   = 5'd3;
  localparam logic [4:0] SEL_DIVU  = 5'd4;
  localparam logic [4:0] SEL_REM   = 5'd5;
  localparam logic [4:0] SEL_REMU  = 5'd6;
  localparam logic [4:0] SEL_MULW  = 5'd24;
  localparam logic [4:0] SEL_DIVW  = 5'd25;
  localparam logic [4:0] SEL_DIVUW = 5'd26;
  localparam logic [4:0] SEL_REMW  = 5'd27;
  localparam logic [4:0] SEL_REMUW = 5'd28;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic valid;
    logic is_mul;
    logic is_word;
    logic is_signed;
    logic is_rem;
  } op_t;

  function automatic op_t decode_sel(input logic [4:0] s);
    op_t o;
    o = '0;
    case (s)
      SEL_MUL:   begin o.valid = 1'b1; o.is_mul = 1'b1; end
      SEL_DIV:   begin o.valid = 1'b1; o.is_signed = 1'b1; end
      SEL_DIVU:  begin o.valid = 1'b1; end
      SEL_REM:   begin o.valid = 1'b1; o.is_signed = 1'b1; o.is_rem = 1'b1; end
      SEL_REMU:  begin o.valid = 1'b1; o.is_rem = 1'b1; end
      SEL_MULW:  begin o.valid = 1'b1; o.is_mul = 1'b1; o.is_word = 1'b1; end
      SEL_DIVW:  begin o.valid = 1'b1; o.is_signed = 1'b1; o.is_word = 1'b1; end
      SEL_DIVUW: begin o.valid = 1'b1; o.is_word = 1'b1; end
      SEL_REMW:  begin o.valid = 1'b1; o.is_signed = 1'b1; o.is_rem = 1'b1; o.is_word = 1'b1; end
      SEL_REMUW: begin o.valid = 1'b1; o.is_rem = 1'b1; o.is_word = 1'b1; end
      default:   o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [W64-1:0] sext32(input logic [W32-1:0] v);
    return {{W32{v[W32-1]}}, v};
  endfunction

  function automatic logic [W64-1:0] cond_neg(input logic [W64-1:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle radix-2 multiplier / restoring divider with RV64 M semantics
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int N = W64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   sel,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         busy
);

  state_t state_q, state_d;
  logic   accept;

  op_t          op_in;
  logic [N-1:0] a_ext, b_ext, a_mag, b_mag, fast_res;
  logic         a_neg, b_neg, div_zero, ovf, fast;

  logic         q_mul, q_word, q_rem, neg_quo, neg_rem;
  logic [N:0]   acc, acc_n;
  logic [N-1:0] mcand, mcand_n, mplier, mplier_n;
  logic [6:0]   cnt;
  logic [N:0]   shifted;
  logic [N+1:0] diff;
  logic [N-1:0] quo_s, rem_s, pick, final_res;

  // Request decode: word ops are narrowed and re-extended before anything else looks at them.
  always_comb begin
    op_in = decode_sel(sel);
    if (op_in.is_word) begin
      a_ext = op_in.is_signed ? sext32(A[31:0]) : {32'b0, A[31:0]};
      b_ext = op_in.is_signed ? sext32(B[31:0]) : {32'b0, B[31:0]};
    end else begin
      a_ext = A;
      b_ext = B;
    end
    a_neg    = op_in.is_signed & a_ext[N-1];
    b_neg    = op_in.is_signed & b_ext[N-1];
    a_mag    = cond_neg(a_ext, a_neg);
    b_mag    = cond_neg(b_ext, b_neg);
    div_zero = op_in.valid & ~op_in.is_mul & (b_ext == '0);
    ovf      = op_in.valid & ~op_in.is_mul & op_in.is_signed & (b_ext == '1) &
               (op_in.is_word ? (A[31:0] == 32'h8000_0000) : (A == {1'b1, {(N-1){1'b0}}}));
    fast     = ~op_in.valid | div_zero | ovf;
    if (!op_in.valid) begin
      fast_res = '0;
    end else if (div_zero) begin
      fast_res = op_in.is_rem ? (op_in.is_word ? sext32(a_ext[31:0]) : a_ext) : '1;
    end else begin
      fast_res = op_in.is_rem ? '0 : a_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (!flush && in_valid) begin
          accept  = 1'b1;
          state_d = fast ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush)              state_d = IDLE;
        else if (cnt == 7'd1)   state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One iteration of either algorithm; the divider reuses acc as the partial remainder.
  always_comb begin
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    shifted  = {acc[N-1:0], mplier[N-1]};
    diff     = {1'b0, shifted} - {2'b00, mcand};
    if (q_mul) begin
      acc_n    = acc + (mplier[0] ? {1'b0, mcand} : {(N+1){1'b0}});
      mcand_n  = {mcand[N-2:0], 1'b0};
      mplier_n = {1'b0, mplier[N-1:1]};
    end else if (!diff[N+1]) begin
      acc_n    = diff[N:0];
      mplier_n = {mplier[N-2:0], 1'b1};
    end else begin
      acc_n    = shifted;
      mplier_n = {mplier[N-2:0], 1'b0};
    end
    quo_s = cond_neg(mplier_n, neg_quo);
    rem_s = cond_neg(acc_n[N-1:0], neg_rem);
    if (q_mul)      pick = acc_n[N-1:0];
    else if (q_rem) pick = rem_s;
    else            pick = quo_s;
    final_res = q_word ? sext32(pick[31:0]) : pick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_mul   <= 1'b0;
      q_word  <= 1'b0;
      q_rem   <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      res     <= '0;
    end else if (accept) begin
      q_mul   <= op_in.is_mul;
      q_word  <= op_in.is_word;
      q_rem   <= op_in.is_rem;
      neg_quo <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      acc     <= '0;
      if (op_in.is_mul) begin
        mcand  <= a_ext;
        mplier <= b_ext;
      end else begin
        mcand  <= b_mag;
        // Word dividends sit in the top half so 32 shifts bring them fully into the remainder.
        mplier <= op_in.is_word ? {a_mag[31:0], 32'b0} : a_mag;
      end
      if (fast) res <= fast_res;
      else      cnt <= op_in.is_word ? 7'(W32) : 7'(W64);
    end else if (state_q == CALC && !flush) begin
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      cnt    <= cnt - 7'd1;
      if (cnt == 7'd1) res <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized scoreboard bench for muldiv_seq against a plain-arithmetic model
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [4:0]  sel;
  logic [63:0] A, B, res;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  bit seen   = 0;
  bit stray  = 0;

  logic [63:0] exp_q[$];
  logic [4:0]  sel_q[$];
  int          lat_q[$];
  int          acc_q[$];

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .A(A), .B(B), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_res(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [31:0] ua, ub, t;
    logic [63:0] minv;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    minv = 64'h8000_0000_0000_0000;
    case (s)
      5'd2:  return a * b;
      5'd3:  begin if (b == 0) return '1; if (a == minv && b == '1) return a; return sa / sb; end
      5'd4:  begin if (b == 0) return '1; return a / b; end
      5'd5:  begin if (b == 0) return a; if (a == minv && b == '1) return 0; return sa % sb; end
      5'd6:  begin if (b == 0) return a; return a % b; end
      5'd24: begin t = ua * ub; return sx(t); end
      5'd25: begin if (ub == 0) return '1; if (ua == 32'h8000_0000 && ub == '1) return sx(ua);
               t = wa / wb; return sx(t); end
      5'd26: begin if (ub == 0) return '1; t = ua / ub; return sx(t); end
      5'd27: begin if (ub == 0) return sx(ua); if (ua == 32'h8000_0000 && ub == '1) return 0;
               t = wa % wb; return sx(t); end
      5'd28: begin if (ub == 0) return sx(ua); t = ua % ub; return sx(t); end
      default: return 0;
    endcase
  endfunction

  // Cycles from the accepting edge to the first cycle showing out_valid.
  function automatic int ref_lat(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b);
    bit word, mul;
    word = (s >= 5'd24 && s <= 5'd28);
    mul  = (s == 5'd2 || s == 5'd24);
    if (!(word || (s >= 5'd2 && s <= 5'd6))) return 1;
    if (!mul) begin
      if (word ? (b[31:0] == 0) : (b == 0)) return 1;
      if ((s == 5'd3 || s == 5'd5) && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
      if ((s == 5'd25 || s == 5'd27) && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
    end
    return word ? 33 : 65;
  endfunction

  task automatic issue(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b, input bit track);
    int t = 0;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin chk("issue_timeout", {63'b0, in_ready}, 64'd1); return; end
    sel = s; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    if (track) begin
      exp_q.push_back(ref_res(s, a, b));
      sel_q.push_back(s);
      lat_q.push_back(ref_lat(s, a, b));
      acc_q.push_back(ncyc);
    end
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin @(negedge clk); t++; end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = {$urandom(), 32'h8000_0000};
      4: v = 64'($urandom_range(0, 100));
      5: v = {32'($urandom_range(0, 3)), $urandom()};
      default: ;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        if (!stray) chk("stray_out_valid", {63'b0, out_valid}, 64'd0);
        stray = 1;
      end else begin
        if (!seen) begin
          chk($sformatf("latency sel=%0d", sel_q[0]), 64'(ncyc - acc_q[0]), 64'(lat_q[0]));
          seen = 1;
        end
        if (out_ready) begin
          chk($sformatf("res sel=%0d", sel_q[0]), res, exp_q[0]);
          void'(exp_q.pop_front()); void'(sel_q.pop_front());
          void'(lat_q.pop_front()); void'(acc_q.pop_front());
          seen = 0;
        end
      end
    end else begin
      stray = 0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  codes [0:10];
    logic [63:0] hold;
    int t;
    codes = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd7};
    rst = 1'b1; in_valid = 1'b0; sel = '0; A = '0; B = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst busy", {63'b0, busy}, 64'd0);
    chk("rst res", res, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(SEL_MUL, '1, 64'd3, 1);
    issue(SEL_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1);
    issue(SEL_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1);
    issue(SEL_REMU, 64'd7, 64'd0, 1);
    issue(SEL_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1);
    issue(SEL_DIVUW, 64'h1_0000_0010, 64'd4, 1);
    issue(SEL_DIV, 64'h8000_0000_0000_0000, '1, 1);
    issue(5'd0, 64'd5, 64'd6, 1);
    drain();

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    issue(SEL_MULW, 64'h0001_0000, 64'h8000, 1);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    chk("stall reached done", {63'b0, out_valid}, 64'd1);
    hold = 64'hFFFF_FFFF_8000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall res", res, hold);
      chk("stall out_valid", {63'b0, out_valid}, 64'd1);
      chk("stall in_ready", {63'b0, in_ready}, 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Flush at CALC cycle 10 discards the divide.
    issue(SEL_DIV, 64'd1000, 64'd7, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush in_ready", {63'b0, in_ready}, 64'd1);
    chk("flush out_valid", {63'b0, out_valid}, 64'd0);
    repeat (70) @(negedge clk);
    // flush beats a simultaneous request in IDLE
    sel = SEL_MUL; A = 64'd2; B = 64'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 begin in_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("flush beats in_valid busy", {63'b0, busy}, 64'd0);
    issue(SEL_MUL, 64'd6, 64'd7, 1);
    drain();

    // Asynchronous reset in the middle of a divide.
    issue(SEL_DIVU, 64'd123456789, 64'd321, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst in_ready", {63'b0, in_ready}, 64'd1);
    chk("arst busy", {63'b0, busy}, 64'd0);
    chk("arst out_valid", {63'b0, out_valid}, 64'd0);
    chk("arst res", res, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    issue(SEL_DIVU, 64'd123456789, 64'd321, 1);
    issue(SEL_DIVU, '1, 64'd10, 1);
    issue(SEL_DIVU, {$urandom(), $urandom()}, 64'($urandom()), 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  s;
      logic [63:0] a, b;
      s = codes[$urandom_range(0, 10)];
      a = rnd_op();
      b = rnd_op();
      issue(s, a, b, 1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the M-extension operations that the single-cycle ALU currently computes combinationally (select codes 2–6 and 24–28). It sits beside the ALU in the execute stage and accepts one operation at a time over a valid/ready handshake. It iterates a radix-2 shift-add multiplier or a restoring divider, then returns an N-bit result with RV64 M semantics, including the divide-by-zero and signed-overflow cases.

## Interface
- N, 64, datapath width; only 64 is supported (word ops use the low 32 bits).
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept; high only in IDLE
- sel  in  5  ALU select code: 2 MUL, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 24 MULW, 25 DIVW, 26 DIVUW, 27 REMW, 28 REMUW
- A  in  N  operand A (dividend / multiplicand)
- B  in  N  operand B (divisor / multiplier)
- flush  in  1  abort current operation (pipeline kill)
- out_valid  out  1  result available; high only in DONE
- out_ready  in  1  consumer takes result
- res  out  N  result; word ops sign-extended from bit 31
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE; reset values: in_ready=1, out_valid=0, busy=0, res=0, counter=0.
- IDLE: when in_valid && in_ready, latch sel, operands, and sign flags. For word ops, truncate operands to 32 bits and extend them (signed ops sign-extend, unsigned ops zero-extend), then run with width W=32. Otherwise W=64.
- Divide by zero (the W-bit divisor is 0) goes directly to DONE:
  - quotient = all ones;
  - remainder = dividend (the W-bit value, sign-extended for word ops).
- Signed overflow goes directly to DONE:
  - condition: DIV/REM with A=0x8000_0000_0000_0000 and B=-1, or DIVW/REMW with A[31:0]=0x8000_0000 and B[31:0]=0xFFFF_FFFF;
  - quotient = dividend, remainder = 0.
- Otherwise, enter CALC with counter=W.
- CALC, multiply: each cycle, if multiplier LSB is set, acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1. The result is the low N bits of acc; MULW sign-extends acc[31:0]. Signedness is irrelevant for the low half.
- CALC, divide:
  - operands are converted to magnitudes first (signed ops);
  - each cycle, shift {rem, quo} left by 1; trial-subtract the divisor from rem; if the result is non-negative, keep it and set quo LSB.
  - At exit, negate the quotient if the operand signs differ. Negate the remainder if the dividend was negative.
- Counter decrements each CALC cycle; when it reaches 1, that cycle performs the final step and the next state is DONE.
- DONE: res holds the final value and out_valid=1. On out_ready, return to IDLE (out_valid drops the next cycle). A new request cannot be accepted in the same cycle, because in_ready=0 in DONE.
- res stays stable while out_valid && !out_ready; it keeps its last value in IDLE.
- flush in any state: next state IDLE, out_valid=0, no result delivered. flush wins over a simultaneous in_valid, so nothing is accepted in that cycle.
- An unsupported sel in IDLE is accepted and completes in 1 cycle with res=0 (matches ALU default).
- rst asserted mid-operation: immediate return to reset values; the partial result is discarded.

## Timing
- Accept at edge T0 (in_valid && in_ready sampled).
- 64-bit mul/div: CALC during cycles T0+1..T0+64; out_valid high from T0+65.
- Word ops: out_valid high from T0+33.
- Zero-divisor, overflow, and unsupported-sel fast paths: out_valid high from T0+1.
- Throughput: one op per latency+1 cycles minimum (DONE→IDLE costs one cycle).
- No combinational path from in_valid or out_ready to in_ready or out_valid; both are decoded from registered state only.

## Structure
- Shared package muldiv_pkg holds:
  - localparams for the select codes (shared with the ALU decoder);
  - the state enum {IDLE, CALC, DONE};
  - W64=64 and W32=32.
- No sub-module required. Sign pre-/post-processing (abs, negate, sign-extend) can be a function in the package.
- Datapath registers: acc/rem (N+1 bits), multiplicand/divisor (N), multiplier/quotient (N), counter (7 bits), and the latched sel plus sign flags.

## Test plan
- MUL A=0xFFFF_FFFF_FFFF_FFFF, B=3 → res=0xFFFF_FFFF_FFFF_FFFD, out_valid exactly 65 cycles after accept.
- DIV A=-7, B=2 → res=-3; REM A=-7, B=2 → res=-1; REMU A=7, B=0 → res=7 with out_valid at T0+1.
- DIVW A=0x0000_0000_8000_0000, B=0xFFFF_FFFF → res=0xFFFF_FFFF_8000_0000 (overflow fast path, 1 cycle); DIVUW A=0x1_0000_0010, B=4 → res=4 after 33 cycles.
- MULW A=0x0001_0000, B=0x8000 → res=0xFFFF_FFFF_8000_0000; hold out_ready=0 for 5 cycles → res and out_valid remain stable, in_ready stays 0.
- flush at CALC cycle 10 of a DIV → out_valid never rises, in_ready=1 next cycle; then a new MUL 6×7 completes with res=42.
- rst pulse asynchronously mid-CALC → all outputs at reset values within the same cycle; back-to-back DIVU ops afterwards give correct results.
